// File: rtl/arrow_pkg.sv
// arrow_pkg -- shared types and constants for the falling-arrow tracker.
//
// Contents:
//   rot_e        arrow direction (UP, DOWN, LEFT, RIGHT)
//   slot_t       one arrow slot: valid, x, y, rotate
//   SCREEN_H     visible rows; an arrow whose y reaches this value is gone
//   SPRITE_*     sprite geometry (long axis 32, short axis 16, 24-row shaft)
//   DEF_*        default tuning values used by arrow_track's parameters
//   arrow_mask() shape lookup for the canonical (UP) orientation
package arrow_pkg;

    localparam int X_W     = 11;
    localparam int Y_W     = 10;
    localparam int COLOR_W = 12;

    localparam int SCREEN_H     = 480;
    localparam int SPRITE_LONG  = 32;
    localparam int SPRITE_SHORT = 16;
    localparam int SHAFT_ROWS   = 24;
    localparam int SHAFT_COL_LO = 4;
    localparam int SHAFT_COL_HI = 11;

    localparam int                 DEF_NUM_ARROWS      = 8;
    localparam int                 DEF_SPEED           = 2;
    localparam int                 DEF_TARGET_Y        = 400;
    localparam int                 DEF_HIT_WINDOW      = 16;
    localparam logic [COLOR_W-1:0] DEF_TARGET_COLOR    = 12'hF00;
    localparam logic [COLOR_W-1:0] DEF_NONTARGET_COLOR = 12'hFF0;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } rot_e;

    typedef struct packed {
        logic           valid;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        rot_e           rotate;
    } slot_t;

    // Canonical arrow on a 16-wide x 32-tall grid: rows 0..23 are an 8-pixel
    // shaft, rows 24..31 a head that loses one column on each side per row.
    function automatic logic arrow_mask(input logic [4:0] row, input logic [3:0] col);
        logic [4:0] k;
        logic       hit;
        k = row - 5'(SHAFT_ROWS);
        if (row < 5'(SHAFT_ROWS)) begin
            hit = (col >= 4'(SHAFT_COL_LO)) && (col <= 4'(SHAFT_COL_HI));
        end else begin
            hit = ({1'b0, col} >= k) && ({1'b0, col} <= (5'd15 - k));
        end
        return hit;
    endfunction

endpackage

// File: rtl/arrow_shape.sv
// arrow_shape -- combinational coverage test for one arrow sprite.
//
// Ports:
//   rel_x_i    raster x minus sprite origin x (all-ones when left of origin)
//   rel_y_i    raster y minus sprite origin y (all-ones when above origin)
//   rotate_i   arrow direction; UP/DOWN are 16x32, LEFT/RIGHT are 32x16
//   covered_o  1 when the relative position is inside the arrow shape
//
// DOWN is UP mirrored top-to-bottom. RIGHT is the transpose of UP (the
// raster x offset walks along the arrow's length), LEFT is RIGHT mirrored
// left-to-right.
module arrow_shape
    import arrow_pkg::*;
(
    input  logic [X_W-1:0] rel_x_i,
    input  logic [Y_W-1:0] rel_y_i,
    input  rot_e           rotate_i,
    output logic           covered_o
);

    logic       in_box;
    logic [4:0] row;
    logic [3:0] col;

    always_comb begin
        in_box = 1'b0;
        row    = '0;
        col    = '0;
        case (rotate_i)
            UP, DOWN: begin
                in_box = (rel_x_i < X_W'(SPRITE_SHORT)) && (rel_y_i < Y_W'(SPRITE_LONG));
                row    = rel_y_i[4:0];
                col    = rel_x_i[3:0];
                if (rotate_i == DOWN) begin
                    row = 5'(SPRITE_LONG - 1) - row;
                end
            end
            default: begin
                in_box = (rel_x_i < X_W'(SPRITE_LONG)) && (rel_y_i < Y_W'(SPRITE_SHORT));
                row    = rel_x_i[4:0];
                col    = rel_y_i[3:0];
                if (rotate_i == LEFT) begin
                    row = 5'(SPRITE_LONG - 1) - row;
                end
            end
        endcase
        covered_o = in_box && arrow_mask(row, col);
    end

endmodule

// File: rtl/arrow_track.sv
// arrow_track -- slot table of falling arrows with hit scoring and a
// 2-stage sprite renderer.
//
// Ports:
//   clk_in, rst_in                   clock, synchronous active-high reset
//   hcount_in/vcount_in              raster position being drawn
//   new_frame_in                     one-cycle pulse per frame; arrows descend
//   spawn_valid_in/spawn_ready_out   spawn handshake
//   spawn_x_in/spawn_rotate_in       column and direction of a new arrow
//   hit_in/hit_rotate_in             player press pulse and its direction
//   pixel_out/in_sprite_out          colour/coverage for the raster position
//                                    presented two cycles earlier
//   hit_out/miss_out                 one-cycle scoring pulses
//   active_count_out                 number of occupied slots
//
// Spawn handshake: a spawn transfers on a rising edge where spawn_valid_in
// and spawn_ready_out are both high. spawn_ready_out depends only on the
// registered slot table (high iff some slot is free), never on
// spawn_valid_in, so a held request is taken the cycle after a slot frees.
module arrow_track
    import arrow_pkg::*;
#(
    parameter int                  NUM_ARROWS      = DEF_NUM_ARROWS,
    parameter int                  SPEED           = DEF_SPEED,
    parameter int                  TARGET_Y        = DEF_TARGET_Y,
    parameter int                  HIT_WINDOW      = DEF_HIT_WINDOW,
    parameter logic [COLOR_W-1:0]  TARGET_COLOR    = DEF_TARGET_COLOR,
    parameter logic [COLOR_W-1:0]  NONTARGET_COLOR = DEF_NONTARGET_COLOR,
    localparam int                 CNT_W           = $clog2(NUM_ARROWS + 1)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [X_W-1:0]     hcount_in,
    input  logic [Y_W-1:0]     vcount_in,
    input  logic               new_frame_in,
    input  logic               spawn_valid_in,
    output logic               spawn_ready_out,
    input  logic [X_W-1:0]     spawn_x_in,
    input  logic [1:0]         spawn_rotate_in,
    input  logic               hit_in,
    input  logic [1:0]         hit_rotate_in,
    output logic [COLOR_W-1:0] pixel_out,
    output logic               in_sprite_out,
    output logic               hit_out,
    output logic               miss_out,
    output logic [CNT_W-1:0]   active_count_out
);

    localparam int WIN_LO = TARGET_Y - HIT_WINDOW;
    localparam int WIN_HI = TARGET_Y + HIT_WINDOW;

    // ------------------------------------------------------------------
    // Slot table
    // ------------------------------------------------------------------
    slot_t slot_q [NUM_ARROWS];
    slot_t slot_d [NUM_ARROWS];
    logic  hit_q, hit_d;
    logic  miss_q, miss_d;

    logic [NUM_ARROWS-1:0] in_win;
    logic [CNT_W-1:0]      count;
    logic                  any_free;

    always_comb begin
        in_win   = '0;
        count    = '0;
        any_free = 1'b0;
        for (int i = 0; i < NUM_ARROWS; i++) begin
            in_win[i] = (int'(slot_q[i].y) >= WIN_LO) && (int'(slot_q[i].y) <= WIN_HI);
            count     = count + CNT_W'(slot_q[i].valid);
            any_free  = any_free | ~slot_q[i].valid;
        end
    end

    // Every decision below is made on the registered table, so a slot freed
    // this cycle still looks occupied to the spawn search and only becomes
    // spawnable next cycle. A slot claimed by the hit is removed instead of
    // being moved, so a same-cycle frame tick never shifts the judged arrow.
    logic           spawn_taken;
    logic           hit_taken;
    logic           expire_any;
    logic [Y_W:0]   next_y;

    always_comb begin
        spawn_taken = 1'b0;
        hit_taken   = 1'b0;
        expire_any  = 1'b0;
        next_y      = '0;
        for (int i = 0; i < NUM_ARROWS; i++) begin
            slot_d[i] = slot_q[i];
            next_y    = {1'b0, slot_q[i].y} + (Y_W + 1)'(SPEED);
            if (slot_q[i].valid) begin
                if (hit_in && !hit_taken && in_win[i] &&
                    (slot_q[i].rotate == rot_e'(hit_rotate_in))) begin
                    slot_d[i].valid = 1'b0;
                    hit_taken       = 1'b1;
                end else if (new_frame_in) begin
                    if (next_y >= (Y_W + 1)'(SCREEN_H)) begin
                        slot_d[i].valid = 1'b0;
                        expire_any      = 1'b1;
                    end else begin
                        slot_d[i].y = next_y[Y_W-1:0];
                    end
                end
            end else if (spawn_valid_in && !spawn_taken) begin
                slot_d[i].valid  = 1'b1;
                slot_d[i].x      = spawn_x_in;
                slot_d[i].y      = '0;
                slot_d[i].rotate = rot_e'(spawn_rotate_in);
                spawn_taken      = 1'b1;
            end
        end
        hit_d  = hit_in && hit_taken;
        // Any number of expiries plus an unmatched press collapse to one pulse.
        miss_d = expire_any || (hit_in && !hit_taken);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_ARROWS; i++) begin
                slot_q[i] <= '0;
            end
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ARROWS; i++) begin
                slot_q[i] <= slot_d[i];
            end
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    // ------------------------------------------------------------------
    // Renderer: stage 1 registers the raster position, stage 2 registers
    // the colour computed against the slot table.
    // ------------------------------------------------------------------
    logic [X_W-1:0]     h_q;
    logic [Y_W-1:0]     v_q;
    logic [COLOR_W-1:0] pixel_q, pixel_d;
    logic               cov_q, cov_d;

    logic [X_W-1:0]        rel_x   [NUM_ARROWS];
    logic [Y_W-1:0]        rel_y   [NUM_ARROWS];
    logic [NUM_ARROWS-1:0] covered;

    for (genvar g = 0; g < NUM_ARROWS; g++) begin : g_slot
        // Positions left of / above the origin map to all-ones, which is
        // outside every sprite box, so subtraction never wraps into a hit.
        assign rel_x[g] = (h_q >= slot_q[g].x) ? (h_q - slot_q[g].x) : '1;
        assign rel_y[g] = (v_q >= slot_q[g].y) ? (v_q - slot_q[g].y) : '1;

        arrow_shape u_shape (
            .rel_x_i   (rel_x[g]),
            .rel_y_i   (rel_y[g]),
            .rotate_i  (slot_q[g].rotate),
            .covered_o (covered[g])
        );
    end

    always_comb begin
        pixel_d = '0;
        cov_d   = 1'b0;
        for (int i = 0; i < NUM_ARROWS; i++) begin
            if (slot_q[i].valid && covered[i] && !cov_d) begin
                cov_d   = 1'b1;
                pixel_d = in_win[i] ? TARGET_COLOR : NONTARGET_COLOR;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            h_q     <= '0;
            v_q     <= '0;
            pixel_q <= '0;
            cov_q   <= 1'b0;
        end else begin
            h_q     <= hcount_in;
            v_q     <= vcount_in;
            pixel_q <= pixel_d;
            cov_q   <= cov_d;
        end
    end

    assign spawn_ready_out  = any_free;
    assign pixel_out        = pixel_q;
    assign in_sprite_out    = cov_q;
    assign hit_out          = hit_q;
    assign miss_out         = miss_q;
    assign active_count_out = count;

endmodule

// File: tb/tb_arrow_track.sv
// tb_arrow_track -- directed self-checking bench for arrow_track.
module tb_arrow_track;
    import arrow_pkg::*;

    localparam logic [11:0] TGT = 12'hF00;
    localparam logic [11:0] NTG = 12'hFF0;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        new_frame_in;
    logic        spawn_valid_in;
    logic        spawn_ready_out;
    logic [10:0] spawn_x_in;
    logic [1:0]  spawn_rotate_in;
    logic        hit_in;
    logic [1:0]  hit_rotate_in;
    logic [11:0] pixel_out;
    logic        in_sprite_out;
    logic        hit_out;
    logic        miss_out;
    logic [3:0]  active_count_out;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard: {in_sprite, pixel} expected per raster vector.
    logic [12:0] exp_q[$];
    logic [10:0] ph_q[$];
    logic [9:0]  pv_q[$];
    logic [12:0] pe_q[$];

    arrow_track dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .new_frame_in     (new_frame_in),
        .spawn_valid_in   (spawn_valid_in),
        .spawn_ready_out  (spawn_ready_out),
        .spawn_x_in       (spawn_x_in),
        .spawn_rotate_in  (spawn_rotate_in),
        .hit_in           (hit_in),
        .hit_rotate_in    (hit_rotate_in),
        .pixel_out        (pixel_out),
        .in_sprite_out    (in_sprite_out),
        .hit_out          (hit_out),
        .miss_out         (miss_out),
        .active_count_out (active_count_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic frame();
        new_frame_in = 1'b1;
        step();
        new_frame_in = 1'b0;
        step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic spawn_one(input logic [10:0] x, input logic [1:0] rot);
        spawn_valid_in  = 1'b1;
        spawn_x_in      = x;
        spawn_rotate_in = rot;
        step();
        spawn_valid_in  = 1'b0;
    endtask

    task automatic press(input logic [1:0] rot);
        hit_in        = 1'b1;
        hit_rotate_in = rot;
        step();
        hit_in        = 1'b0;
    endtask

    task automatic add_px(input logic [10:0] h, input logic [9:0] v,
                          input logic cov, input logic [11:0] pix);
        ph_q.push_back(h);
        pv_q.push_back(v);
        pe_q.push_back({cov, pix});
    endtask

    // Stream the pending raster vectors; each result appears two edges
    // after its position is presented.
    task automatic flush_raster(input string tag);
        int          n;
        logic [12:0] e;
        n = ph_q.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                hcount_in = ph_q[i];
                vcount_in = pv_q[i];
                exp_q.push_back(pe_q[i]);
            end else begin
                hcount_in = '0;
                vcount_in = '0;
            end
            step();
            if (i >= 1) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("%s_sb_empty", tag), 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s[%0d]", tag, i - 1), {19'd0, in_sprite_out, pixel_out}, {19'd0, e});
                end
            end
        end
        ph_q.delete();
        pv_q.delete();
        pe_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_in          = 1'b1;
        hcount_in       = '0;
        vcount_in       = '0;
        new_frame_in    = 1'b0;
        spawn_valid_in  = 1'b1;
        spawn_x_in      = 11'd50;
        spawn_rotate_in = 2'd0;
        hit_in          = 1'b0;
        hit_rotate_in   = 2'd0;
        step();
        step();
        rst_in         = 1'b0;
        spawn_valid_in = 1'b0;
        chk("rst_count", active_count_out, 0);
        chk("rst_ready", spawn_ready_out, 1);
        chk("rst_hit", hit_out, 0);
        chk("rst_miss", miss_out, 0);
        chk("rst_pix", {in_sprite_out, pixel_out}, 0);

        // First arrow, vertical, and its shape near the origin.
        spawn_one(11'd100, 2'd0);
        chk("spawn1_count", active_count_out, 1);
        chk("spawn1_ready", spawn_ready_out, 1);
        add_px(11'd104, 10'd0,  1'b1, NTG);
        add_px(11'd99,  10'd0,  1'b0, 12'h000);
        add_px(11'd104, 10'd31, 1'b0, 12'h000);
        add_px(11'd107, 10'd31, 1'b1, NTG);
        add_px(11'd115, 10'd24, 1'b1, NTG);
        add_px(11'd116, 10'd0,  1'b0, 12'h000);
        add_px(11'd111, 10'd23, 1'b1, NTG);
        add_px(11'd112, 10'd23, 1'b0, 12'h000);
        flush_raster("shape_up");

        // Advance to y=396: inside the window, target colour.
        frames(198);
        chk("adv396_count", active_count_out, 1);
        add_px(11'd104, 10'd396, 1'b1, TGT);
        add_px(11'd104, 10'd395, 1'b0, 12'h000);
        flush_raster("win396");

        press(2'd1);
        chk("wrong_rot_miss", miss_out, 1);
        chk("wrong_rot_hit", hit_out, 0);
        chk("wrong_rot_count", active_count_out, 1);
        step();
        chk("miss_pulse_end", miss_out, 0);

        press(2'd0);
        chk("good_hit", hit_out, 1);
        chk("good_hit_miss", miss_out, 0);
        chk("good_hit_count", active_count_out, 0);
        step();
        chk("hit_pulse_end", hit_out, 0);

        // A (LEFT) ends at the window edge y=384, B (RIGHT) trails at 368.
        spawn_one(11'd200, 2'd2);
        frames(8);
        spawn_one(11'd300, 2'd3);
        frames(184);
        chk("ab_count", active_count_out, 2);
        add_px(11'd231, 10'd388, 1'b1, TGT);
        add_px(11'd200, 10'd391, 1'b1, TGT);
        add_px(11'd200, 10'd388, 1'b0, 12'h000);
        add_px(11'd300, 10'd372, 1'b1, NTG);
        flush_raster("shape_lr");

        hit_in        = 1'b1;
        hit_rotate_in = 2'd2;
        new_frame_in  = 1'b1;
        step();
        hit_in       = 1'b0;
        new_frame_in = 1'b0;
        chk("hit_frame_hit", hit_out, 1);
        chk("hit_frame_miss", miss_out, 0);
        chk("hit_frame_count", active_count_out, 1);
        step();
        add_px(11'd300, 10'd372, 1'b0, 12'h000);
        add_px(11'd300, 10'd381, 1'b1, NTG);
        add_px(11'd231, 10'd388, 1'b0, 12'h000);
        flush_raster("post_hit_frame");

        // B: 370 -> 478, then expires.
        frames(54);
        chk("b478_count", active_count_out, 1);
        new_frame_in = 1'b1;
        step();
        new_frame_in = 1'b0;
        chk("b_expire_miss", miss_out, 1);
        chk("b_expire_count", active_count_out, 0);
        step();

        // Two arrows expire together: one miss pulse.
        spawn_one(11'd10, 2'd0);
        spawn_one(11'd60, 2'd1);
        frames(239);
        chk("pair478_count", active_count_out, 2);
        chk("pair478_miss", miss_out, 0);
        new_frame_in = 1'b1;
        step();
        new_frame_in = 1'b0;
        chk("pair_expire_miss", miss_out, 1);
        chk("pair_expire_hit", hit_out, 0);
        chk("pair_expire_count", active_count_out, 0);
        step();
        chk("pair_single_pulse", miss_out, 0);

        // Fill every slot; the ninth request is held until one frees.
        for (int i = 0; i < 8; i++) begin
            spawn_valid_in  = 1'b1;
            spawn_x_in      = 11'(50 * i);
            spawn_rotate_in = 2'(i % 4);
            step();
        end
        spawn_x_in      = 11'd600;
        spawn_rotate_in = 2'd0;
        chk("full_count", active_count_out, 8);
        chk("full_ready", spawn_ready_out, 0);
        step();
        chk("no_overfill", active_count_out, 8);
        frames(200);
        hit_in        = 1'b1;
        hit_rotate_in = 2'd1;
        step();
        hit_in = 1'b0;
        chk("free1_hit", hit_out, 1);
        chk("free1_ready", spawn_ready_out, 1);
        chk("free1_count", active_count_out, 7);
        step();
        spawn_valid_in = 1'b0;
        chk("held_spawn_count", active_count_out, 8);
        chk("held_spawn_ready", spawn_ready_out, 0);
        add_px(11'd604, 10'd0,   1'b1, NTG);
        add_px(11'd204, 10'd400, 1'b1, TGT);
        flush_raster("refill");
        press(2'd1);
        chk("skip_to_slot5_hit", hit_out, 1);
        chk("skip_to_slot5_count", active_count_out, 7);
        step();

        // Reset wins over spawn, hit and frame in the same cycle.
        rst_in          = 1'b1;
        spawn_valid_in  = 1'b1;
        spawn_x_in      = 11'd700;
        hit_in          = 1'b1;
        hit_rotate_in   = 2'd0;
        new_frame_in    = 1'b1;
        hcount_in       = 11'd4;
        vcount_in       = 10'd400;
        step();
        rst_in         = 1'b0;
        spawn_valid_in = 1'b0;
        hit_in         = 1'b0;
        new_frame_in   = 1'b0;
        hcount_in      = '0;
        vcount_in      = '0;
        chk("mid_rst_count", active_count_out, 0);
        chk("mid_rst_hit", hit_out, 0);
        chk("mid_rst_miss", miss_out, 0);
        chk("mid_rst_pix", {in_sprite_out, pixel_out}, 0);
        chk("mid_rst_ready", spawn_ready_out, 1);
        step();
        chk("mid_rst_no_spawn", active_count_out, 0);

        // Origin near the right edge: no wrap-around coverage.
        spawn_one(11'd2040, 2'd3);
        add_px(11'd2040, 10'd4, 1'b1, NTG);
        add_px(11'd5,    10'd4, 1'b0, 12'h000);
        add_px(11'd2040, 10'd3, 1'b0, 12'h000);
        flush_raster("wrap");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
